// File: rtl/qos_pkg.sv
// Shared QoS definitions for the age-boost front end and the downstream arbiter.
package qos_pkg;

    localparam int unsigned NUM_REQ = 32;
    localparam int unsigned QOS_W   = 4;
    localparam int unsigned QOS_MAX = 15;

    typedef logic [QOS_W-1:0] qos_t;

endpackage : qos_pkg

// File: rtl/qos_age_lane.sv
// One requestor lane: wait-age counter, age-derived QoS boost with clamping,
// and saturation (starvation) flag.
module qos_age_lane
    import qos_pkg::*;
#(
    parameter int unsigned AGE_W     = 8,
    parameter int unsigned AGE_SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic       clr_i,
    input  qos_t       qos_i,
    output qos_t       qos_c,
    output logic       starve_c
);

    // Sum is wide enough that base + boost can never wrap before the clamp.
    localparam int unsigned SUM_W = ((AGE_W > QOS_W) ? AGE_W : QOS_W) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;
    logic [AGE_W-1:0] boost;
    logic [SUM_W-1:0] sum;

    // Clear on idle or on a valid grant (grant beats increment); else saturating count.
    always_comb begin
        age_d = age_q;
        if (!req_i || clr_i) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    // Idle lanes pass their base QoS straight through.
    always_comb begin
        boost = age_q >> AGE_SHIFT;
        sum   = SUM_W'(qos_i) + SUM_W'(boost);
        qos_c = qos_i;
        if (req_i) begin
            qos_c = (sum > SUM_W'(QOS_MAX)) ? QOS_W'(QOS_MAX) : sum[QOS_W-1:0];
        end
    end

    assign starve_c = (age_q == AGE_MAX);

endmodule : qos_age_lane

// File: rtl/qos_age_boost_32.sv
// Ages waiting requests and raises their QoS over time so low-priority
// requestors cannot be starved by the downstream QoS arbiter.
module qos_age_boost_32
    import qos_pkg::*;
#(
    parameter int unsigned AGE_W     = 8,
    parameter int unsigned AGE_SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic [NUM_REQ*QOS_W-1:0]   qos_in,
    input  logic [NUM_REQ-1:0]         grant,
    input  logic                       grant_valid,
    output logic [NUM_REQ-1:0]         req_out,
    output logic [NUM_REQ*QOS_W-1:0]   qos_out,
    output logic [NUM_REQ-1:0]         starve
);

    assign req_out = req_in;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        qos_age_lane #(
            .AGE_W     (AGE_W),
            .AGE_SHIFT (AGE_SHIFT)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .req_i    (req_in[i]),
            .clr_i    (grant_valid & grant[i]),
            .qos_i    (qos_in[QOS_W*i +: QOS_W]),
            .qos_c    (qos_out[QOS_W*i +: QOS_W]),
            .starve_c (starve[i])
        );
    end

endmodule : qos_age_boost_32

// File: tb/tb_qos_age_boost_32.sv
// Directed bench for qos_age_boost_32, including a closed loop against a
// simple highest-QoS / lowest-index arbiter model.
module tb_qos_age_boost_32;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  req_in, grant, req_out, starve;
    logic         grant_valid;
    logic [127:0] qos_in, qos_out;

    logic [31:0]  req2, grant2, req2_out, starve2;
    logic         gv2;
    logic [127:0] qos2_in, qos2_out;
    logic [3:0]   arb_best;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qos_age_boost_32 #(.AGE_W(8), .AGE_SHIFT(4)) u_dut (
        .clk(clk), .rst(rst), .req_in(req_in), .qos_in(qos_in),
        .grant(grant), .grant_valid(grant_valid),
        .req_out(req_out), .qos_out(qos_out), .starve(starve)
    );

    qos_age_boost_32 #(.AGE_W(8), .AGE_SHIFT(2)) u_dut_loop (
        .clk(clk), .rst(rst), .req_in(req2), .qos_in(qos2_in),
        .grant(grant2), .grant_valid(gv2),
        .req_out(req2_out), .qos_out(qos2_out), .starve(starve2)
    );

    // Arbiter model: highest QoS wins, ties go to the lowest index.
    always_comb begin
        gv2      = 1'b0;
        grant2   = '0;
        arb_best = '0;
        for (int i = 0; i < 32; i++) begin
            if (req2_out[i] && (!gv2 || qos2_out[4*i +: 4] > arb_best)) begin
                gv2      = 1'b1;
                arb_best = qos2_out[4*i +: 4];
                grant2   = 32'h1 << i;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] with_lane(input logic [127:0] v, input int i, input logic [3:0] q);
        logic [127:0] r;
        r = v;
        r[4*i +: 4] = q;
        return r;
    endfunction

    logic [127:0] base;
    int           first;

    initial begin
        rst = 1'b1; req_in = '1; qos_in = '0; grant = '0; grant_valid = 1'b0;
        req2 = '0; qos2_in = '0;

        // Reset holds ages at zero with all requests active.
        step(3);
        check("rst_qos", qos_out, 128'h0);
        check("rst_starve", 128'(starve), 128'h0);
        check("rst_req_out", 128'(req_out), 128'(32'hFFFF_FFFF));
        rst = 1'b0;
        #1;
        check("post_rst_k0", qos_out, 128'h0);
        step(15);
        check("post_rst_k15", qos_out, 128'h0);
        step(1);
        check("post_rst_k16", qos_out, {32{4'h1}});

        // Asynchronous reset mid-operation, between clock edges.
        rst = 1'b1;
        #1;
        check("async_rst_qos", qos_out, 128'h0);
        step(1);
        rst = 1'b0; req_in = '0;

        // Lane 5 aging at shift 4; other lanes idle must pass through.
        base = with_lane({32{4'h7}}, 5, 4'd3);
        qos_in = base; req_in = 32'h1 << 5;
        #1;
        check("l5_k0", qos_out, base);
        step(15);
        check("l5_k15", qos_out, base);
        step(1);
        check("l5_k16", qos_out, with_lane(base, 5, 4'd4));
        step(15);
        check("l5_k31", qos_out, with_lane(base, 5, 4'd4));
        step(1);
        check("l5_k32", qos_out, with_lane(base, 5, 4'd5));
        check("l5_starve", 128'(starve), 128'h0);
        req_in = '0;
        step(1);

        // Lane 9 from base 14 clamps at 15.
        base = with_lane({32{4'hA}}, 9, 4'd14);
        qos_in = base; req_in = 32'h1 << 9;
        step(15);
        check("l9_k15", qos_out, base);
        step(1);
        check("l9_k16", qos_out, with_lane(base, 9, 4'd15));
        step(16);
        check("l9_k32_noclip", qos_out, with_lane(base, 9, 4'd15));
        step(16);
        check("l9_k48", qos_out, with_lane(base, 9, 4'd15));
        req_in = '0;
        step(1);
        req_in = 32'h1 << 9;
        #1;
        check("l9_cleared", qos_out, base);
        req_in = '0;
        step(1);

        // Lane 2 grant handling.
        base = with_lane(128'h0, 2, 4'd5);
        qos_in = base; req_in = 32'h1 << 2;
        step(20);
        check("l2_k20", qos_out, with_lane(base, 2, 4'd6));
        grant = 32'h4; grant_valid = 1'b1;
        step(1);
        grant = '0; grant_valid = 1'b0;
        #1;
        check("l2_granted", qos_out, base);
        grant = 32'h4; grant_valid = 1'b0;
        step(16);
        check("l2_grant_novalid", qos_out, with_lane(base, 2, 4'd6));
        grant = 32'h8; grant_valid = 1'b1;
        step(16);
        check("l2_other_grant", qos_out, with_lane(base, 2, 4'd7));
        grant = '0; grant_valid = 1'b0; req_in = '0;
        step(1);

        // Lane 31 saturation and starve flag.
        qos_in = '0; req_in = 32'h1 << 31;
        step(254);
        check("l31_k254_starve", 128'(starve), 128'h0);
        check("l31_k254_qos", qos_out, with_lane(128'h0, 31, 4'd15));
        step(1);
        check("l31_k255_starve", 128'(starve), 128'(32'h8000_0000));
        step(5);
        check("l31_k260_starve", 128'(starve), 128'(32'h8000_0000));
        req_in = '0;
        #1;
        check("l31_drop_qos", qos_out, 128'h0);
        check("l31_drop_starve_pre", 128'(starve), 128'(32'h8000_0000));
        step(1);
        check("l31_drop_starve", 128'(starve), 128'h0);

        // Closed loop at shift 2: lane 0 (qos 2) ties lane 1 (qos 10) at age 32.
        qos2_in = with_lane(with_lane(128'h0, 0, 4'd2), 1, 4'd10);
        req2 = 32'h3;
        first = -1;
        #1;
        for (int k = 0; k <= 40; k++) begin
            if (first < 0 && gv2 && grant2[0]) first = k;
            if (first < 0) step(1);
        end
        check("loop_first_grant", 128'(first), 128'(32));
        req2 = '0;
        step(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_qos_age_boost_32

// File: doc/qos_age_boost_32.md
QOS_AGE_BOOST_32 -- requirements
Module: qos_age_boost_32

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter AGE_W, default 8, giving the width of each per-requestor wait counter.
REQ-002 The block SHALL have parameter AGE_SHIFT, default 4, such that a waiting requestor gains one QoS level every 2^AGE_SHIFT cycles; the legal range is 0 to AGE_W-1.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have one clock, port clk, input, 1 bit, on which all state changes at the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, as its reset; rst is asynchronous and active-high.
REQ-005 The block SHALL have port req_in, input, 32 bits, carrying the raw request vector from the requestors.
REQ-006 The block SHALL have port qos_in, input, 128 bits, carrying the base QoS of each requestor, 4 bits per requestor; requestor i uses bits [4i+3:4i].
REQ-007 The block SHALL have ports grant (input, 32 bits) and grant_valid (input, 1 bit), fed back from the downstream qos_arbiter_32.
REQ-008 The block SHALL have port req_out, output, 32 bits, carrying the request vector to the arbiter.
REQ-009 The block SHALL have port qos_out, output, 128 bits, carrying the boosted QoS to the arbiter, packed the same way as qos_in.
REQ-010 The block SHALL have port starve, output, 32 bits; starve[i] is high when the wait counter of requestor i is saturated.

Function
REQ-011 req_out SHALL equal req_in combinationally, with zero latency.
REQ-012 For each requestor i, a counter age[i] of AGE_W bits SHALL be kept.
REQ-013 At each rising clk edge, age[i] SHALL clear to 0 when req_in[i]=0, or when grant_valid=1 and grant[i]=1.
REQ-014 Otherwise, age[i] SHALL increment by 1 and saturate at 2^AGE_W-1.
REQ-015 When a grant and a held request occur in the same cycle, the clear SHALL win over the increment.
REQ-016 A grant bit on a non-requesting line, or any grant bits while grant_valid=0, SHALL have no effect.
REQ-017 The boost for requestor i SHALL be boost[i] = age[i] >> AGE_SHIFT.
REQ-018 The qos_out field for requestor i SHALL be min(qos_in[i] + boost[i], 15), computed without wrap-around.
REQ-019 qos_out SHALL be combinational from the registered age and the current qos_in, so the arbiter sees the boost in the same cycle.
REQ-020 For any requestor with req_in[i]=0, the qos_out field SHALL equal its qos_in field unchanged.
REQ-021 starve[i] SHALL be 1 exactly when age[i] equals 2^AGE_W-1.
REQ-022 All 32 lanes SHALL behave independently; no lane may affect another.

Reset
REQ-023 While rst=1, every age[i] SHALL be 0 and starve SHALL be 0.
REQ-024 While rst=1, qos_out SHALL equal qos_in and req_out SHALL equal req_in.
REQ-025 Asserting rst mid-operation SHALL clear all ages immediately, without waiting for a clock edge.
REQ-026 After rst deasserts, counting SHALL resume at the first rising clk edge.

Structure
REQ-027 A shared package qos_pkg SHALL hold NUM_REQ=32, QOS_W=4 and QOS_MAX=15; the same package SHALL be used by qos_arbiter_32.
REQ-028 A sub-module qos_age_lane SHALL hold one age counter plus its boost and saturation logic; the top SHALL instantiate 32 lanes with a generate loop.

Verification
REQ-029 Scenario: rst held with req_in=all-ones and qos_in=0 -> qos_out=0, starve=0; after rst falls the ages count from 0.
REQ-030 Scenario: AGE_SHIFT=4, req_in[5]=1, qos_in[5]=3, never granted -> qos_out[5] reads 3 on cycles 0-15, 4 on cycles 16-31, and 5 from cycle 32.
REQ-031 Scenario: qos_in[9]=14, req held for 48 cycles with no grant -> qos_out[9] clamps at 15 and does not wrap to 0.
REQ-032 Scenario: req[2] held 20 cycles, then grant_valid=1 with grant=0x4 for one cycle -> next cycle age resets, qos_out[2] returns to its qos_in value; grant=0x4 with grant_valid=0 -> age keeps counting.
REQ-033 Scenario: AGE_W=8, req[31] held 255 cycles without grant -> starve[31]=1 and stays 1; dropping req_in[31] -> starve[31]=0 on the next cycle.
REQ-034 Scenario: closed loop with qos_arbiter_32, req[0] at qos 2 and req[1] at qos 10 held continuously, AGE_SHIFT=2 -> requestor 0 is granted within 40 cycles (no starvation).
